// File: rtl/clk_div_monitor_if.sv
// Divided-clock monitor bus: the three clocks under check, a clear pulse,
// and the lock/fault status returned to the datapath.
interface clk_div_monitor_if;
    logic       clk4f_in;
    logic       clk2f_in;
    logic       clk_in;
    logic       clr;
    logic       locked;
    logic       fault;
    logic [2:0] err_period;
    logic       err_phase;

    modport master (
        output clk4f_in, clk2f_in, clk_in, clr,
        input  locked, fault, err_period, err_phase
    );

    modport slave (
        input  clk4f_in, clk2f_in, clk_in, clr,
        output locked, fault, err_period, err_phase
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Samples clk4f/clk2f/clk as data in the clk32f domain, checks exact half-periods
// and rising-edge alignment, and reports lock or sticky fault status.
module clk_div_monitor #(
    parameter int HALF4        = 4,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             clk32f,
    input  logic             rst,
    clk_div_monitor_if.slave bus
);
    localparam int NCH = 3;
    localparam int GW  = $clog2(LOCK_PERIODS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_FAULT} state_t;

    state_t              r_state, w_next;
    logic [NCH-1:0]      r_s, r_s_d, r_edge, r_rise;
    logic                r_lvl_clk;
    logic [NCH-1:0][5:0] r_cnt;
    logic [NCH-1:0]      r_armed;
    logic [GW-1:0]       r_good;
    logic [NCH-1:0]      r_err_period;
    logic                r_err_phase;
    logic [NCH-1:0]      w_per_err;
    logic                w_ph_err, w_any_err, w_go_idle, w_flag_en;

    // Channel ch runs at half-period HALF4 << ch (clk4f, clk2f, clk).
    function automatic logic [5:0] half_of(input int ch);
        return 6'(HALF4 << ch);
    endfunction

    // Edge/rise are registered so all checks act one cycle after detection.
    always_ff @(posedge clk32f or negedge rst) begin
        if (!rst) begin
            r_s       <= '0;
            r_s_d     <= '0;
            r_edge    <= '0;
            r_rise    <= '0;
            r_lvl_clk <= 1'b0;
        end else begin
            r_s       <= {bus.clk_in, bus.clk2f_in, bus.clk4f_in};
            r_s_d     <= r_s;
            r_edge    <= r_s ^ r_s_d;
            r_rise    <= r_s & ~r_s_d;
            r_lvl_clk <= r_s[2];
        end
    end

    always_comb begin
        w_per_err = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_armed[i]) begin
                if (r_edge[i]) w_per_err[i] = (r_cnt[i] != half_of(i));
                else           w_per_err[i] = (r_cnt[i] == half_of(i) + 6'd1);
            end
        end
    end

    // Slower rises must land on faster rises; also flag a clk2f rise when clk is
    // low and overdue to rise.
    assign w_ph_err = (r_state != S_IDLE) &&
                      ((r_rise[2] && !r_rise[1]) ||
                       (r_rise[1] && !r_rise[0]) ||
                       (r_rise[1] && r_armed[2] && !r_edge[2] && !r_lvl_clk &&
                        r_cnt[2] == half_of(2)));

    assign w_any_err = (|w_per_err) || w_ph_err;
    assign w_go_idle = (w_next == S_IDLE);
    assign w_flag_en = (r_state == S_LOCKED) || (r_state == S_FAULT);

    always_ff @(posedge clk32f or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_armed <= '0;
        end else if (w_go_idle) begin
            r_cnt   <= '0;
            r_armed <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (r_edge[i])              r_cnt[i] <= 6'd1;
                else if (r_cnt[i] != 6'd63) r_cnt[i] <= r_cnt[i] + 6'd1;
                if (r_state != S_IDLE && r_edge[i]) r_armed[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk32f or negedge rst) begin
        if (!rst)                                              r_good <= '0;
        else if (r_state != S_ACQUIRE || w_next != S_ACQUIRE) r_good <= '0;
        else if (r_rise[2])                                    r_good <= r_good + GW'(1);
    end

    always_ff @(posedge clk32f or negedge rst) begin
        if (!rst) begin
            r_err_period <= '0;
            r_err_phase  <= 1'b0;
        end else if (bus.clr) begin
            r_err_period <= '0;
            r_err_phase  <= 1'b0;
        end else if (w_flag_en) begin
            r_err_period <= r_err_period | w_per_err;
            r_err_phase  <= r_err_phase | w_ph_err;
        end
    end

    always_ff @(posedge clk32f or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // clr overrides everything, including an error in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (r_rise[2]) w_next = S_ACQUIRE;
            S_ACQUIRE: begin
                if (w_any_err)
                    w_next = S_IDLE;
                else if (r_rise[2] && r_good == GW'(LOCK_PERIODS - 1))
                    w_next = S_LOCKED;
            end
            S_LOCKED:  if (w_any_err) w_next = S_FAULT;
            S_FAULT:   w_next = S_FAULT;
            default:   w_next = S_IDLE;
        endcase
        if (bus.clr) w_next = S_IDLE;
    end

    always_comb begin
        bus.locked     = (r_state == S_LOCKED);
        bus.fault      = (r_state == S_FAULT);
        bus.err_period = r_err_period;
        bus.err_phase  = r_err_phase;
    end
endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Checker that consumes the divided clocks produced by the clock divider (clk4f, clk2f, clk) and confirms they hold the required ratios and alignment relative to clk32f. It samples the three clocks as data in the clk32f domain, measures each half-period, and checks that their rising edges coincide. It then reports lock or sticky fault status to the surrounding datapath. It is the receiving end of the divider outputs and gates downstream blocks that depend on them.

## Interface
- HALF4, 4: required clk4f half-period in clk32f cycles; clk2f requires 2*HALF4, clk requires 4*HALF4.
- LOCK_PERIODS, 2: consecutive error-free full clk periods needed to declare lock.
- clk32f  input  1  Reference clock; all logic on its rising edge.
- rst  input  1  Asynchronous, active-low reset.
- clk4f_in  input  1  Divided clock under check, nominal clk32f/8.
- clk2f_in  input  1  Divided clock under check, nominal clk32f/16.
- clk_in  input  1  Divided clock under check, nominal clk32f/32.
- clr  input  1  Synchronous clear of faults and flags; active-high, one-cycle pulse.
- locked  output  1  High while the state is LOCKED.
- fault  output  1  High while the state is FAULT.
- err_period  output  3  Sticky per-channel period error: bit0 clk4f, bit1 clk2f, bit2 clk.
- err_phase  output  1  Sticky rising-edge alignment error.

## Operation
- Input stage: the three inputs are registered once (s) and again (s_d). Edge = s != s_d; rise = s & ~s_d.
- Per-channel counter, 6 bits, saturating at 63:
  - Loads 1 on any detected edge of its channel.
  - Otherwise increments.
- Per-channel armed bit: set on the first edge of that channel after leaving IDLE. Cleared on entering IDLE.
- Period error, raised only on an armed channel:
  - An edge arrives with count != required half-period, or
  - count reaches required half-period + 1 with no edge (covers a stuck clock).
- Phase error: any of the following when the comparison is evaluated.
  - rise(clk_in) without rise(clk2f_in) in the same cycle.
  - rise(clk2f_in) without rise(clk4f_in) in the same cycle.
  - rise(clk2f_in) without rise(clk_in) on a cycle where clk_in counter == 16*HALF4/4... comparison is one-directional only: the slower channel's rise must coincide with the faster one's.
- FSM, four states:
  - IDLE: entered by reset or clr. Counters and armed bits clear. Go to ACQUIRE on rise(clk_in).
  - ACQUIRE: good-period counter counts rise(clk_in) events with no error since the previous rise.
    - Any period or phase error returns to IDLE; sticky flags are not set.
    - Reaching LOCK_PERIODS goes to LOCKED.
  - LOCKED: any error sets the matching sticky bit(s) and goes to FAULT.
  - FAULT: holds until clr (to IDLE) or reset. Further errors still OR into the sticky bits.
- clr wins over a simultaneous error. The error is discarded and the state goes to IDLE.
- Several channels failing in the same cycle set all corresponding bits at once.

## Timing
- Reset values: locked=0, fault=0, err_period=000, err_phase=0, state IDLE, counters 0, armed bits 0.
- Reset mid-operation returns everything to reset values immediately (asynchronous), regardless of state.
- Input changes before clk32f edge k. Edge is detected in the cycle after edge k+1. Flags and state update at edge k+2, so outputs are visible 2 cycles after the input change.
- With an ideal divider and defaults, locked rises 2 + 2*32 = 66 clk32f cycles after the first clk_in rise is sampled.
- Stuck clock: the flag appears at count HALF+1, plus 2 cycles of pipeline latency.
- Ratio check is exact. A one-cycle deviation in any half-period is an error.

## Test plan
- Reset held low for 3 cycles while inputs toggle randomly -> all outputs 0. State IDLE after release, with no flag set.
- Ideal divider (clk4f/clk2f/clk at 8/16/32-cycle periods, rising together) -> locked=1 exactly 66 cycles after the first sampled clk_in rise. fault stays 0 for 1000 cycles.
- Locked, then stretch one clk2f high phase to 9 cycles -> err_period=010, err_phase=1 on the misaligned rise, fault=1, locked=0.
- Locked, then hold clk4f_in at 1 -> err_period[0]=1 two cycles after its counter reaches 5. Other bits stay 0.
- Glitch during ACQUIRE (clk_in high phase of 15 cycles) -> returns to IDLE, flags stay 0, relocks after the next 2 clean periods.
- In FAULT, pulse clr in the same cycle as a new error -> flags 0, state IDLE. Then reset asserted mid-lock -> immediate outputs 0.
